// File: rtl/aq_f_spsram_pkg.sv
// Shared definitions for the single-port SRAM sequencer: state encoding,
// default geometry and SRAM pin polarities.
package aq_f_spsram_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 59;

    localparam logic CEN_ACTIVE = 1'b0;
    localparam logic GWEN_WRITE = 1'b1;

    typedef enum logic {
        INIT,
        IDLE
    } state_e;

endpackage

// File: rtl/aq_f_spsram_ctrl.sv
// Sequencer in front of a single-port SRAM macro: zero-fills the array after reset or
// invalidate, then serves reads and bit-masked writes with a one-deep response path.
module aq_f_spsram_ctrl
    import aq_f_spsram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  inv_req,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_stall;
    logic                  req_acc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            rsp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rsp_vld_q  <= rsp_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rsp_vld_d  = rsp_vld_q;
        req_rdy    = 1'b0;
        req_acc    = 1'b0;
        sram_a     = '0;
        sram_cen   = ~CEN_ACTIVE;
        sram_gwen  = ~GWEN_WRITE;
        sram_wen   = '0;
        sram_d     = '0;
        // Q is only held while the macro is deselected, so a stalled response blocks access
        rsp_stall  = rsp_vld_q && !rsp_rdy;

        unique case (state_q)
            INIT: begin
                sram_cen   = CEN_ACTIVE;
                sram_gwen  = GWEN_WRITE;
                sram_wen   = '1;
                sram_a     = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                req_rdy = !inv_req && !rsp_stall;
                req_acc = req_vld && req_rdy;
                if (rsp_vld_q && rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                end
                if (req_acc) begin
                    sram_cen = CEN_ACTIVE;
                    sram_a   = req_addr;
                    if (req_wr) begin
                        sram_gwen = GWEN_WRITE;
                        sram_wen  = req_wmask;
                        sram_d    = req_wdata;
                    end else begin
                        rsp_vld_d = 1'b1;
                    end
                end
                if (inv_req && !rsp_stall) begin
                    state_d    = INIT;
                    init_cnt_d = '0;
                end
            end
        endcase
    end

    assign init_done = (state_q == IDLE);
    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = sram_q;

endmodule

// File: tb/tb_aq_f_spsram_ctrl.sv
// Randomised bench for aq_f_spsram_ctrl: a behavioural SRAM macro plus a transaction-level
// model of the controller's contract, checked every cycle, with directed literal checks.
module tb_aq_f_spsram_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 59;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          inv_req = 1'b0;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    always #5 CLK = ~CLK;

    aq_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
        .inv_req(inv_req), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    // Behavioural SRAM macro: bit-masked write, registered read, Q held otherwise.
    logic [DW-1:0] macro_mem [DEPTH];
    logic [DW-1:0] macro_q;
    assign sram_q = macro_q;
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (sram_gwen) macro_mem[sram_a] <= (macro_mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
            else           macro_q <= macro_mem[sram_a];
        end
    end

    // Contract model
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_init = 1'b1;
    int            m_cnt = 0;
    bit            m_rsp_vld = 1'b0;
    logic [DW-1:0] m_rsp_data = '0;
    bit            m_acc = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc_num = 0;
    int stall_left = 0;
    bit rdy_dflt = 1'b1;
    bit obs_rsp_vld;
    bit obs_init_done;
    logic [DW-1:0] obs_rdata;
    logic [DW-1:0] hs_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s @%0t: bound expired", name, $time);
    endtask

    function automatic logic [DW-1:0] val(input int i);
        return DW'(64'h0ABC_0000 + 64'(i) * 64'h111);
    endfunction

    // One clock cycle: entered and left at posedge+1; checks at the negedge.
    task automatic cyc();
        logic [DW-1:0] ones;
        bit exp_rdy, stall;
        ones = '1;
        rsp_rdy = (stall_left > 0) ? 1'b0 : rdy_dflt;
        if (stall_left > 0) stall_left--;
        #4;
        cyc_num++;
        obs_rsp_vld   = rsp_vld;
        obs_init_done = init_done;
        obs_rdata     = rsp_rdata;
        if (rsp_vld && rsp_rdy) hs_q.push_back(rsp_rdata);
        if (m_init) begin
            chk("init_done", 64'(init_done), 64'(0));
            chk("req_rdy",   64'(req_rdy),   64'(0));
            chk("rsp_vld",   64'(rsp_vld),   64'(0));
            chk("init_cen",  64'(sram_cen),  64'(0));
            chk("init_gwen", 64'(sram_gwen), 64'(1));
            chk("init_a",    64'(sram_a),    64'(m_cnt));
            chk("init_d",    64'(sram_d),    64'(0));
            chk("init_wen",  64'(sram_wen),  64'(ones));
            m_mem[m_cnt] = '0;
            m_cnt++;
            m_acc = 1'b0;
            if (m_cnt == DEPTH) begin
                m_init = 1'b0;
                m_cnt  = 0;
            end
        end else begin
            stall   = m_rsp_vld && !rsp_rdy;
            exp_rdy = !inv_req && !stall;
            m_acc   = req_vld && exp_rdy;
            chk("init_done", 64'(init_done), 64'(1));
            chk("req_rdy",   64'(req_rdy),   64'(exp_rdy));
            chk("rsp_vld",   64'(rsp_vld),   64'(m_rsp_vld));
            if (m_rsp_vld) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_data));
            if (m_acc) begin
                chk("acc_cen", 64'(sram_cen), 64'(0));
                chk("acc_a",   64'(sram_a),   64'(req_addr));
                chk("acc_gwen", 64'(sram_gwen), 64'(req_wr));
                if (req_wr) begin
                    chk("wr_wen", 64'(sram_wen), 64'(req_wmask));
                    chk("wr_d",   64'(sram_d),   64'(req_wdata));
                    m_mem[req_addr] = (m_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                end else begin
                    chk("rd_wen", 64'(sram_wen), 64'(0));
                end
            end else begin
                chk("idle_cen", 64'(sram_cen), 64'(1));
            end
            if (m_acc && !req_wr) begin
                m_rsp_vld  = 1'b1;
                m_rsp_data = m_mem[req_addr];
            end else if (m_rsp_vld && rsp_rdy) begin
                m_rsp_vld = 1'b0;
            end
            if (inv_req && !stall) begin
                m_init = 1'b1;
                m_cnt  = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input bit wr, input int addr, input logic [DW-1:0] data,
                        input logic [DW-1:0] mask);
        int n;
        n = 0;
        req_vld = 1'b1; req_wr = wr; req_addr = AW'(addr); req_wdata = data; req_wmask = mask;
        do begin
            cyc();
            n++;
        end while (!m_acc && n < 50);
        if (!m_acc) timeout("send");
        req_vld = 1'b0;
    endtask

    task automatic wait_init_done(output int cycles);
        cycles = 0;
        while (!obs_init_done && cycles < 400) begin
            cyc();
            cycles++;
        end
        if (!obs_init_done) timeout("init_done");
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [63:0]   r;
        int            n, nv;
        ones = '1;

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        obs_init_done = 1'b0;
        wait_init_done(n);
        chk("init_done_cycle", 64'(n), 64'(257));

        // Full write, read back
        send(1'b1, 'h2A, DW'(64'h5A5A), ones);
        send(1'b0, 'h2A, '0, '0);
        cyc();
        chk("rd_vld_next", 64'(obs_rsp_vld), 64'(1));
        chk("rd_full", 64'(obs_rdata), 64'h5A5A);

        // Masked write merges low byte
        send(1'b1, 'h2A, DW'(64'h1234), DW'(64'h00FF));
        send(1'b0, 'h2A, '0, '0);
        cyc();
        chk("rd_masked", 64'(obs_rdata), 64'h5A34);

        // Four back-to-back reads
        for (int i = 0; i < 4; i++) send(1'b1, 'h10 + i, val(i), ones);
        hs_q.delete();
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 'h10 + i, '0, '0);
            if (obs_rsp_vld) nv++;
        end
        cyc();
        if (obs_rsp_vld) nv++;
        chk("b2b_vld_cycles", 64'(nv), 64'(4));
        chk("b2b_count", 64'(hs_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < hs_q.size(); i++) chk("b2b_data", 64'(hs_q[i]), 64'(val(i)));

        // Same reads with a 3-cycle consumer stall after the first response
        hs_q.delete();
        send(1'b0, 'h10, '0, '0);
        stall_left = 3;
        for (int i = 1; i < 4; i++) send(1'b0, 'h10 + i, '0, '0);
        cyc();
        chk("stall_count", 64'(hs_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < hs_q.size(); i++) chk("stall_data", 64'(hs_q[i]), 64'(val(i)));

        // Invalidate held while a response is pending
        send(1'b0, 'h2A, '0, '0);
        stall_left = 2;
        inv_req = 1'b1;
        cyc();
        cyc();
        chk("inv_wait_done", 64'(obs_init_done), 64'(1));
        cyc();
        inv_req = 1'b0;
        chk("inv_rsp_drained", 64'(obs_rdata), 64'h5A34);
        obs_init_done = 1'b0;
        wait_init_done(n);
        chk("reinit_cycles", 64'(n), 64'(257));
        send(1'b0, 'h2A, '0, '0);
        cyc();
        chk("rd_after_inv_vld", 64'(obs_rsp_vld), 64'(1));
        chk("rd_after_inv", 64'(obs_rdata), 64'(0));

        // Random traffic over a small address window
        for (int i = 0; i < 1500; i++) begin
            req_vld   = ($urandom_range(0, 3) != 0);
            req_wr    = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 15));
            r         = {$urandom, $urandom};
            req_wdata = r[DW-1:0];
            r         = {$urandom, $urandom};
            req_wmask = ($urandom_range(0, 1) == 1) ? ones : r[DW-1:0];
            rdy_dflt  = ($urandom_range(0, 9) < 7);
            inv_req   = ($urandom_range(0, 299) == 0);
            cyc();
        end
        req_vld  = 1'b0;
        inv_req  = 1'b0;
        rdy_dflt = 1'b1;

        // Reset mid-INIT at init_cnt=100
        n = 0;
        inv_req = 1'b1;
        while (!m_init && n < 20) begin
            cyc();
            n++;
        end
        inv_req = 1'b0;
        if (!m_init) timeout("enter_init");
        n = 0;
        while (m_cnt != 100 && n < 300) begin
            cyc();
            n++;
        end
        chk("a_before_rst", 64'(sram_a), 64'(100));
        RST = 1'b1;
        #1;
        chk("rst_a",         64'(sram_a),    64'(0));
        chk("rst_cen",       64'(sram_cen),  64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));
        chk("rst_req_rdy",   64'(req_rdy),   64'(0));
        chk("rst_rsp_vld",   64'(rsp_vld),   64'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_init = 1'b1;
        m_cnt = 0;
        m_rsp_vld = 1'b0;
        obs_init_done = 1'b0;
        wait_init_done(n);
        chk("post_rst_init_cycles", 64'(n), 64'(257));
        send(1'b0, 'h2A, '0, '0);
        cyc();
        chk("post_rst_rd", 64'(obs_rdata), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
